multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low: clk  in  1  rising-edge clock; reset_n  in  1  async active-low reset.
REQ-002 The block SHALL take these inputs: opcode  in  6  IR[31:26]; funct  in  6  IR[5:0]; zero  in  1  ALU equality flag; mem_ready  in  1  memory handshake done.
REQ-003 The block SHALL drive these strobes: pc_write  out  1; ir_write  out  1; mem_read  out  1; mem_write  out  1; reg_write  out  1.
REQ-004 The block SHALL drive these selects: reg_dst  out  2  (0 rt, 1 rd, 2 $31); mem_to_reg  out  2  (0 ALU, 1 mem, 2 PC+4); alu_src_b  out  1  (0 reg, 1 ext imm); ext_op  out  1  (0 zero, 1 sign); alu_op  out  ALUOP_W  (0 ADD, 1 SUB, 2 OR, 3 LUI); npc_op  out  2  (0 PC+4, 1 branch, 2 jump, 3 jr).
REQ-005 The block SHALL drive these status outputs: state  out  3  current state; illegal  out  1  one-cycle undefined-instruction pulse.
REQ-006 The block SHALL have parameter ALUOP_W, default 4, giving the alu_op width; it SHALL be >= 2.
REQ-007 The block SHALL have parameter CNT_W, default 32, giving the performance counter width.

Function
REQ-008 The block SHALL decode addu, subu, jr (opcode 0, funct 0x21/0x23/0x08), ori 0x0d, lw 0x23, sw 0x2b, beq 0x04, lui 0x0f, j 0x02 and jal 0x03; any other combination SHALL be illegal.
REQ-009 The state machine SHALL use encodings FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; unused codes SHALL return to FETCH on the next edge.
REQ-010 All outputs SHALL be combinational from state, opcode, funct and zero; a strobe not named for a state SHALL be 0 in that state.
REQ-011 In FETCH the block SHALL assert mem_read; when mem_ready=1 it SHALL also assert ir_write and pc_write with npc_op=0 and go to DECODE, otherwise it SHALL hold FETCH.
REQ-012 In DECODE, j SHALL assert pc_write with npc_op=2 and go to FETCH.
REQ-013 In DECODE, jal SHALL additionally assert reg_write with reg_dst=2 and mem_to_reg=2.
REQ-014 In DECODE, jr SHALL assert pc_write with npc_op=3 and go to FETCH.
REQ-015 In DECODE, an illegal instruction SHALL pulse illegal and go to FETCH with no architectural write.
REQ-016 In DECODE, all other legal instructions SHALL go to EXEC.
REQ-017 In EXEC, beq SHALL set alu_op=SUB, ext_op=1 and alu_src_b=0, SHALL assert pc_write with npc_op=1 only when zero=1, and SHALL go to FETCH.
REQ-018 In EXEC, lw and sw SHALL use ADD with sign-extended imm and go to MEM; all other instructions SHALL go to WB.
REQ-019 In MEM, lw SHALL assert mem_read and sw SHALL assert mem_write until mem_ready=1; on mem_ready, lw SHALL go to WB and sw SHALL go to FETCH.
REQ-020 In WB the block SHALL assert reg_write: R-type with reg_dst=1 and mem_to_reg=0; ori and lui with reg_dst=0 and mem_to_reg=0; lw with reg_dst=0 and mem_to_reg=1. It SHALL then go to FETCH.
REQ-021 ALU selects SHALL remain stable from EXEC through WB of the same instruction; ori SHALL use OR with zero-extension, lui SHALL use LUI, addu SHALL use ADD and subu SHALL use SUB.
REQ-022 mem_ready SHALL be sampled only in FETCH and MEM and ignored elsewhere; the number of wait cycles SHALL be unbounded.

Reset
REQ-023 While reset_n=0 the state SHALL be FETCH and every strobe and illegal SHALL be forced to 0 asynchronously.
REQ-024 Deassertion of reset_n SHALL take effect at the next clk edge.
REQ-025 Reset asserted mid-instruction SHALL abandon the instruction with no further writes.

Configuration
REQ-026 With MULTICYCLE_CTRL_PERF_EN defined, the block SHALL add outputs cycle_cnt and instret_cnt, each CNT_W bits and reset to 0.
REQ-027 With MULTICYCLE_CTRL_PERF_EN defined, cycle_cnt SHALL increment every cycle out of reset and instret_cnt SHALL increment on each instruction completion (a legal instruction's transition to FETCH); both SHALL wrap modulo 2^CNT_W.
REQ-028 Without MULTICYCLE_CTRL_PERF_EN, neither counter port nor its logic SHALL exist.

Structure
REQ-029 A shared package SHALL hold the state enum, the opcode and funct constants, and the alu_op, npc_op, reg_dst and mem_to_reg encodings.
REQ-030 A combinational sub-module mc_decode SHALL map opcode and funct to one-hot instruction flags plus illegal_dec; the FSM and output logic SHALL live in multicycle_ctrl.

Verification
REQ-031 The bench SHALL drive addu with mem_ready=1 throughout and check the state sequence 0,1,2,4,0 and a single reg_write cycle with reg_dst=1.
REQ-032 The bench SHALL drive lw with mem_ready held low for 3 cycles in MEM and check mem_read high for 4 MEM cycles, then WB with mem_to_reg=1.
REQ-033 The bench SHALL drive beq with zero=1 and then with zero=0 and check pc_write with npc_op=1 in EXEC only for zero=1; both cases SHALL return to FETCH.
REQ-034 The bench SHALL drive jal and check, in DECODE, pc_write=1, npc_op=2, reg_write=1, reg_dst=2 and mem_to_reg=2, with the next state FETCH.
REQ-035 The bench SHALL drive opcode 0x3f and check one illegal pulse in DECODE with no reg_write, mem_write or pc_write; with PERF enabled, instret_cnt SHALL be unchanged.
REQ-036 The bench SHALL drop reset_n during a sw MEM wait and check that mem_write drops immediately and that state reads 0 before the next clk edge.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg
// Shared definitions for the multicycle MIPS-subset controller: the FSM
// state enum, opcode/funct constants, the select encodings driven onto the
// datapath and the one-hot instruction flag bundle produced by mc_decode.
// No ports; imported by mc_decode and multicycle_ctrl.

package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    // ALU operation select (zero-extended to ALUOP_W at the port)
    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_SUB  = 2'd1;
    localparam logic [1:0] ALU_OR   = 2'd2;
    localparam logic [1:0] ALU_LUI  = 2'd3;

    // Next-PC source select
    localparam logic [1:0] NPC_SEQ    = 2'd0;
    localparam logic [1:0] NPC_BRANCH = 2'd1;
    localparam logic [1:0] NPC_JUMP   = 2'd2;
    localparam logic [1:0] NPC_JR     = 2'd3;

    // Register-file write address select
    localparam logic [1:0] REG_DST_RT = 2'd0;
    localparam logic [1:0] REG_DST_RD = 2'd1;
    localparam logic [1:0] REG_DST_RA = 2'd2;

    // Register-file write data select
    localparam logic [1:0] MTR_ALU = 2'd0;
    localparam logic [1:0] MTR_MEM = 2'd1;
    localparam logic [1:0] MTR_PC4 = 2'd2;

    // One-hot instruction flags; all zero means the instruction is undefined
    typedef struct packed {
        logic addu;
        logic subu;
        logic jr;
        logic ori;
        logic lw;
        logic sw;
        logic beq;
        logic lui;
        logic j;
        logic jal;
    } instr_t;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// mc_decode
// Purely combinational instruction decoder for multicycle_ctrl.
// Ports:
//   opcode      in  6   IR[31:26]
//   funct       in  6   IR[5:0]
//   instr       out     one-hot instruction flags (instr_t)
//   illegal_dec out 1   no supported instruction matched

module mc_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output instr_t     instr,
    output logic       illegal_dec
);

    // funct only matters for opcode 0; every unlisted combination leaves
    // all flags clear, which is what marks the instruction as illegal.
    always_comb begin
        instr = '0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: instr.addu = 1'b1;
                    FN_SUBU: instr.subu = 1'b1;
                    FN_JR:   instr.jr   = 1'b1;
                    default: ;
                endcase
            end
            OP_ORI:  instr.ori = 1'b1;
            OP_LW:   instr.lw  = 1'b1;
            OP_SW:   instr.sw  = 1'b1;
            OP_BEQ:  instr.beq = 1'b1;
            OP_LUI:  instr.lui = 1'b1;
            OP_J:    instr.j   = 1'b1;
            OP_JAL:  instr.jal = 1'b1;
            default: ;
        endcase
        illegal_dec = (instr == '0);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// FETCH/DECODE/EXEC/MEM/WB control FSM for a multicycle MIPS-subset core.
// Outputs are combinational from the current state and the instruction
// fields; the only register is the state (plus optional counters).
// Ports:
//   clk, reset_n                       clock, async active-low reset
//   opcode, funct, zero, mem_ready     instruction fields, ALU flag, mem handshake
//   pc_write, ir_write, mem_read,
//   mem_write, reg_write               datapath write strobes
//   reg_dst, mem_to_reg, alu_src_b,
//   ext_op, alu_op, npc_op             datapath selects
//   state, illegal                     current state, undefined-instruction pulse
//   cycle_cnt, instret_cnt             only with MULTICYCLE_CTRL_PERF_EN defined
// Build option: MULTICYCLE_CTRL_PERF_EN adds cycle and retired-instruction counters.

module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               ir_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               reg_write,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic               alu_src_b,
    output logic               ext_op,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         npc_op,
    output logic [2:0]         state,
    output logic               illegal
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic [CNT_W-1:0]   instret_cnt
`endif
);

    instr_t     instr;
    logic       illegal_dec;
    state_e     state_q, state_d;

    logic       pc_write_raw, ir_write_raw, mem_read_raw, mem_write_raw;
    logic       reg_write_raw, illegal_raw;
    logic [1:0] npc_sel;
    logic [1:0] alu_sel;

    mc_decode u_decode (
        .opcode      (opcode),
        .funct       (funct),
        .instr       (instr),
        .illegal_dec (illegal_dec)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and strobes. Anything not explicitly raised in a state
    // stays 0, and unused state codes fall through to FETCH.
    always_comb begin
        state_d       = S_FETCH;
        pc_write_raw  = 1'b0;
        ir_write_raw  = 1'b0;
        mem_read_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        illegal_raw   = 1'b0;
        npc_sel       = NPC_SEQ;
        case (state_q)
            S_FETCH: begin
                mem_read_raw = 1'b1;
                if (mem_ready) begin
                    ir_write_raw = 1'b1;
                    pc_write_raw = 1'b1;
                    state_d      = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                if (instr.j || instr.jal) begin
                    pc_write_raw  = 1'b1;
                    npc_sel       = NPC_JUMP;
                    reg_write_raw = instr.jal;
                end else if (instr.jr) begin
                    pc_write_raw = 1'b1;
                    npc_sel      = NPC_JR;
                end else if (illegal_dec) begin
                    illegal_raw = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (instr.beq) begin
                    if (zero) begin
                        pc_write_raw = 1'b1;
                        npc_sel      = NPC_BRANCH;
                    end
                end else if (instr.lw || instr.sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_read_raw  = instr.lw;
                mem_write_raw = instr.sw;
                if (mem_ready) begin
                    state_d = instr.lw ? S_WB : S_FETCH;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_WB: begin
                reg_write_raw = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath selects depend only on the instruction, so they hold steady
    // from EXEC through WB without any extra state.
    always_comb begin
        if (instr.subu || instr.beq) begin
            alu_sel = ALU_SUB;
        end else if (instr.ori) begin
            alu_sel = ALU_OR;
        end else if (instr.lui) begin
            alu_sel = ALU_LUI;
        end else begin
            alu_sel = ALU_ADD;
        end
        alu_src_b = instr.ori || instr.lui || instr.lw || instr.sw;
        ext_op    = !instr.ori;
        if (instr.jal) begin
            reg_dst    = REG_DST_RA;
            mem_to_reg = MTR_PC4;
        end else begin
            reg_dst    = (instr.addu || instr.subu) ? REG_DST_RD : REG_DST_RT;
            mem_to_reg = instr.lw ? MTR_MEM : MTR_ALU;
        end
    end

    assign alu_op = ALUOP_W'(alu_sel);
    assign npc_op = npc_sel;
    assign state  = state_q;

    // Reset forces FETCH, which would otherwise raise mem_read, so strobes
    // are gated with reset_n to drop immediately on assertion.
    assign pc_write  = pc_write_raw  & reset_n;
    assign ir_write  = ir_write_raw  & reset_n;
    assign mem_read  = mem_read_raw  & reset_n;
    assign mem_write = mem_write_raw & reset_n;
    assign reg_write = reg_write_raw & reset_n;
    assign illegal   = illegal_raw   & reset_n;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instret_cnt_q, instret_cnt_d;
    logic             retire;

    // An instruction retires on the cycle its legal path returns to FETCH;
    // the illegal exit from DECODE deliberately does not count.
    always_comb begin
        retire = ((state_q == S_DECODE) && (instr.j || instr.jal || instr.jr))
              || ((state_q == S_EXEC)   && instr.beq)
              || ((state_q == S_MEM)    && instr.sw && mem_ready)
              ||  (state_q == S_WB);
        cycle_cnt_d   = cycle_cnt_q + CNT_W'(1);
        instret_cnt_d = retire ? (instret_cnt_q + CNT_W'(1)) : instret_cnt_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`else
    // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
// Drives directed and random instruction streams into multicycle_ctrl and
// compares every cycle against a per-instruction step list built from the
// instruction's class (fetch, decode, exec, mem, wb phases).

module tb_multicycle_ctrl;

    localparam int ALUOP_W = 4;
    localparam int CNT_W   = 32;

    // Instruction classes known to the reference model
    localparam int C_ADDU = 0, C_SUBU = 1, C_JR = 2, C_ORI = 3, C_LW = 4;
    localparam int C_SW = 5, C_BEQ = 6, C_LUI = 7, C_J = 8, C_JAL = 9, C_ILL = 10;

    logic               clk;
    logic               reset_n;
    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic               zero;
    logic               mem_ready;
    logic               pc_write, ir_write, mem_read, mem_write, reg_write;
    logic [1:0]         reg_dst, mem_to_reg;
    logic               alu_src_b, ext_op;
    logic [ALUOP_W-1:0] alu_op;
    logic [1:0]         npc_op;
    logic [2:0]         state;
    logic               illegal;
    logic [5:0]         strobes;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [CNT_W-1:0]   cycle_cnt, instret_cnt;
`endif

    int compared   = 0;
    int mismatched = 0;
    longint exp_cycles  = 0;
    longint exp_instret = 0;

    // Per-instruction ALU expectations, set by runInstr before EXEC
    int exp_alu, exp_srcb, exp_ext;
    bit ext_matters;

    assign strobes = {pc_write, ir_write, mem_read, mem_write, reg_write, illegal};

    multicycle_ctrl #(.ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_write    (pc_write),
        .ir_write    (ir_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .alu_src_b   (alu_src_b),
        .ext_op      (ext_op),
        .alu_op      (alu_op),
        .npc_op      (npc_op),
        .state       (state),
        .illegal     (illegal)
`ifdef MULTICYCLE_CTRL_PERF_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expv);
        compared++;
        if (got !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, expv, $time);
        end
    endtask

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00:   return (fn == 6'h21) ? C_ADDU : (fn == 6'h23) ? C_SUBU :
                            (fn == 6'h08) ? C_JR : C_ILL;
            6'h0d:   return C_ORI;
            6'h23:   return C_LW;
            6'h2b:   return C_SW;
            6'h04:   return C_BEQ;
            6'h0f:   return C_LUI;
            6'h02:   return C_J;
            6'h03:   return C_JAL;
            default: return C_ILL;
        endcase
    endfunction

    // One clock cycle: drive mem_ready, check outputs mid-cycle, then step
    // the edge and advance the expected counters. Called at posedge+1.
    task automatic applyStimulus(input logic mr, input int exp_state, input logic [5:0] exp_stb,
                                 input int exp_npc, input int exp_rd, input int exp_mtr,
                                 input bit alu_phase, input bit retire);
        mem_ready = mr;
        @(negedge clk);
        checkOutput("state", 64'(state), 64'(exp_state));
        checkOutput("strobes", 64'(strobes), 64'(exp_stb));
        if (exp_stb[5]) checkOutput("npc_op", 64'(npc_op), 64'(exp_npc));
        if (exp_stb[1]) begin
            checkOutput("reg_dst", 64'(reg_dst), 64'(exp_rd));
            checkOutput("mem_to_reg", 64'(mem_to_reg), 64'(exp_mtr));
        end
        if (alu_phase) begin
            checkOutput("alu_op", 64'(alu_op), 64'(exp_alu));
            checkOutput("alu_src_b", 64'(alu_src_b), 64'(exp_srcb));
            if (ext_matters) checkOutput("ext_op", 64'(ext_op), 64'(exp_ext));
        end
`ifdef MULTICYCLE_CTRL_PERF_EN
        checkOutput("cycle_cnt", 64'(cycle_cnt), 64'(exp_cycles));
        checkOutput("instret_cnt", 64'(instret_cnt), 64'(exp_instret));
`endif
        @(posedge clk);
        if (reset_n) begin
            exp_cycles++;
            if (retire) exp_instret++;
        end
        #1;
    endtask

    // Runs one instruction from FETCH back to FETCH, generating the expected
    // step list from the instruction's class.
    task automatic runInstr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int fetch_wait, input int mem_wait);
        int c;
        c = classify(op, fn);
        opcode = op;
        funct  = fn;
        zero   = z;
        for (int i = 0; i < fetch_wait; i++)
            applyStimulus(1'b0, 0, 6'b001000, 0, 0, 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 0, 6'b111000, 0, 0, 0, 1'b0, 1'b0);

        case (c)
            C_J:   begin applyStimulus(1'($urandom_range(0, 1)), 1, 6'b100000, 2, 0, 0, 1'b0, 1'b1); return; end
            C_JAL: begin applyStimulus(1'($urandom_range(0, 1)), 1, 6'b100010, 2, 2, 2, 1'b0, 1'b1); return; end
            C_JR:  begin applyStimulus(1'($urandom_range(0, 1)), 1, 6'b100000, 3, 0, 0, 1'b0, 1'b1); return; end
            C_ILL: begin applyStimulus(1'($urandom_range(0, 1)), 1, 6'b000001, 0, 0, 0, 1'b0, 1'b0); return; end
            default: applyStimulus(1'($urandom_range(0, 1)), 1, 6'b000000, 0, 0, 0, 1'b0, 1'b0);
        endcase

        ext_matters = 1'b0;
        exp_ext     = 0;
        case (c)
            C_ADDU: begin exp_alu = 0; exp_srcb = 0; end
            C_SUBU: begin exp_alu = 1; exp_srcb = 0; end
            C_ORI:  begin exp_alu = 2; exp_srcb = 1; ext_matters = 1'b1; exp_ext = 0; end
            C_LUI:  begin exp_alu = 3; exp_srcb = 1; end
            C_BEQ:  begin exp_alu = 1; exp_srcb = 0; ext_matters = 1'b1; exp_ext = 1; end
            default: begin exp_alu = 0; exp_srcb = 1; ext_matters = 1'b1; exp_ext = 1; end
        endcase

        if (c == C_BEQ) begin
            applyStimulus(1'($urandom_range(0, 1)), 2, z ? 6'b100000 : 6'b000000, 1, 0, 0, 1'b1, 1'b1);
            return;
        end
        applyStimulus(1'($urandom_range(0, 1)), 2, 6'b000000, 0, 0, 0, 1'b1, 1'b0);

        if (c == C_LW || c == C_SW) begin
            for (int i = 0; i < mem_wait; i++)
                applyStimulus(1'b0, 3, (c == C_LW) ? 6'b001000 : 6'b000100, 0, 0, 0, 1'b1, 1'b0);
            applyStimulus(1'b1, 3, (c == C_LW) ? 6'b001000 : 6'b000100, 0, 0, 0, 1'b1, c == C_SW);
            if (c == C_SW) return;
        end

        applyStimulus(1'($urandom_range(0, 1)), 4, 6'b000010, 0,
                      (c == C_ADDU || c == C_SUBU) ? 1 : 0, (c == C_LW) ? 1 : 0, 1'b1, 1'b1);
    endtask

    // Reset asserted while sw waits in MEM: strobes and state must fall
    // before the next clock edge, and the controller restarts in FETCH.
    task automatic resetDuringSw();
        opcode = 6'h2b;
        funct  = 6'($urandom);
        zero   = 1'b0;
        exp_alu = 0; exp_srcb = 1; exp_ext = 1; ext_matters = 1'b1;
        applyStimulus(1'b1, 0, 6'b111000, 0, 0, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1, 6'b000000, 0, 0, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, 2, 6'b000000, 0, 0, 0, 1'b1, 1'b0);
        applyStimulus(1'b0, 3, 6'b000100, 0, 0, 0, 1'b1, 1'b0);
        mem_ready = 1'b0;
        @(negedge clk);
        checkOutput("sw_wait_mem_write", 64'(mem_write), 64'd1);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("rst_mem_write", 64'(mem_write), 64'd0);
        checkOutput("rst_state", 64'(state), 64'd0);
        checkOutput("rst_strobes", 64'(strobes), 64'd0);
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_hold_state", 64'(state), 64'd0);
        checkOutput("rst_hold_strobes", 64'(strobes), 64'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        exp_cycles  = 0;
        exp_instret = 0;
    endtask

    initial begin
        logic [5:0] op_table [10];
        logic [5:0] fn_table [10];
        op_table = '{6'h00, 6'h00, 6'h00, 6'h0d, 6'h23, 6'h2b, 6'h04, 6'h0f, 6'h02, 6'h03};
        fn_table = '{6'h21, 6'h23, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

        reset_n   = 1'b0;
        opcode    = 6'h00;
        funct     = 6'h21;
        zero      = 1'b0;
        mem_ready = 1'b1;
        exp_alu = 0; exp_srcb = 0; exp_ext = 0; ext_matters = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_state", 64'(state), 64'd0);
        checkOutput("reset_strobes", 64'(strobes), 64'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Directed cases
        runInstr(6'h00, 6'h21, 1'b0, 1, 0);   // addu, also exercises a fetch wait
        runInstr(6'h00, 6'h21, 1'b0, 0, 0);   // addu with mem_ready=1 throughout fetch
        runInstr(6'h23, 6'h00, 1'b0, 0, 3);   // lw with three MEM wait cycles
        runInstr(6'h04, 6'h00, 1'b1, 0, 0);   // beq taken
        runInstr(6'h04, 6'h00, 1'b0, 0, 0);   // beq not taken
        runInstr(6'h03, 6'h00, 1'b0, 0, 0);   // jal
        runInstr(6'h3f, 6'h00, 1'b0, 0, 0);   // undefined opcode
        runInstr(6'h00, 6'h20, 1'b0, 0, 0);   // undefined R-type funct
        runInstr(6'h2b, 6'h00, 1'b0, 0, 2);   // sw
        runInstr(6'h0d, 6'h00, 1'b0, 0, 0);   // ori
        runInstr(6'h0f, 6'h00, 1'b0, 0, 0);   // lui
        runInstr(6'h00, 6'h23, 1'b0, 0, 0);   // subu
        runInstr(6'h00, 6'h08, 1'b0, 0, 0);   // jr
        runInstr(6'h02, 6'h00, 1'b0, 0, 0);   // j

        resetDuringSw();
        runInstr(6'h00, 6'h21, 1'b0, 0, 0);

        // Random stream: mostly legal instructions, some arbitrary encodings
        for (int n = 0; n < 150; n++) begin
            int pick;
            logic [5:0] op, fn;
            pick = $urandom_range(0, 11);
            if (pick < 10) begin
                op = op_table[pick];
                fn = (op == 6'h00) ? fn_table[pick] : 6'($urandom);
            end else if (pick == 10) begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end else begin
                op = 6'h00;
                fn = 6'($urandom);
            end
            runInstr(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
